fft_out_serializer: RTL and testbench
=====================================

// Module: fft_out_serializer
// PURPOSE
//  Consumer end of the 8-point FFT core's parallel result bus. Captures one frame of
//  eight packed complex words (b0..b7) in one cycle, then streams them out one word per
//  beat over a valid/ready interface. Sits between the FFT core and narrow downstream
//  logic (UART/DMA/monitor), so that logic does not need a 256-bit datapath.
//  Word format: [DW-1:DW/2] real, [DW/2-1:0] imag, signed Q8.8 at DW=32.
// PARAMETERS
//  DW     32   width of one packed complex word (real and imag halves of DW/2 each)
//  N      8    frame length; fixed at 8 (matches b0..b7); localparam IW=3 is the index width
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    b0..b7 hold a complete FFT frame
//  in_ready   out  1    serializer can accept a frame this cycle
//  b0..b7     in   DW   FFT result words, bin 0..7
//  out_valid  out  1    out_data/out_idx/out_last are valid
//  out_ready  in   1    downstream accepts the current beat
//  out_data   out  DW   current complex word
//  out_idx    out  3    FFT bin index of out_data
//  out_last   out  1    high on the final beat (8th) of a frame
//  busy       out  1    frame held in buffer, not fully sent
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, cnt=0, buffer=0, out_valid=0, out_data=0,
//    out_idx=0, out_last=0, busy=0. The frame in flight is discarded; no beat follows reset.
//  - FSM IDLE: in_ready=1, out_valid=0. On in_valid, capture b0..b7 into buf[0..7],
//    cnt<=0, go to SEND.
//  - FSM SEND: out_valid=1, busy=1; out_data=buf[sel(cnt)], out_idx=sel(cnt), out_last=(cnt==7).
//    Beat fires on out_valid&&out_ready: cnt<=cnt+1. Outputs hold steady while out_ready=0.
//  - Last beat (cnt==7, fires): if in_valid, capture the new frame, cnt<=0, stay in SEND
//    (zero-bubble back-to-back). Otherwise go to IDLE.
//  - in_ready = (state==IDLE) | (state==SEND & cnt==7 & out_ready); combinational,
//    never depends on in_valid.
//  - Latency: frame accepted at edge t -> first beat valid in cycle t+1. Full rate is
//    8 cycles per frame.
//  - b0..b7 are sampled only on capture; later changes do not affect the frame in flight.
//  - All outputs are driven from registers (state, cnt, buf). No arithmetic; data is
//    passed bit-exact.
//  - in_valid in SEND before the last beat is ignored and not captured; the source
//    holds it until in_ready is high.
// CONFIGURATION
//  FFT_OUT_BITREV_EN defined:   sel(cnt)=bitrev3(cnt). Beat order is bins 0,4,2,6,1,5,3,7.
//                               out_idx reports the true bin. Use with bit-reversed-order cores.
//  FFT_OUT_BITREV_EN undefined: sel(cnt)=cnt, natural order 0..7.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> all outputs 0 immediately; after release in_ready=1,
//    out_valid=0.
//  2 Single frame, out_ready=1: bk=32'h0100_0000+k, in_valid 1 cycle -> 8 beats on
//    consecutive cycles, out_data=32'h0100_0000..0007, out_idx=0..7, out_last on beat 7 only.
//  3 Backpressure: out_ready low for 3 cycles at beat 2 -> out_data=..0002 held stable,
//    no beat lost or duplicated, total 11 cycles.
//  4 Back-to-back: in_valid held high with frames A then B -> B captured on A's last
//    beat, B beat 0 on the very next cycle, no idle gap.
//  5 Reset mid-frame after beat 4 -> out_valid=0 at once; next frame starts at
//    out_idx=0 with new data.
//  6 FFT_OUT_BITREV_EN: frame bk=k -> out_data/out_idx order 0,4,2,6,1,5,3,7.
//    Repeat test 2 with the macro undefined to confirm natural order.

Source files
------------

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - serializes one 8-word FFT result frame into a valid/ready word stream
//
// Captures b0..b7 in one cycle, then emits one word per accepted beat.
// Optional macro: FFT_OUT_BITREV_EN selects bit-reversed beat order (0,4,2,6,1,5,3,7);
// out_idx always reports the true bin. Undefined gives natural order 0..7.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready frame handshake; b0..b7 are sampled when both are high
//   b0..b7            packed complex words, bin 0..7 ([DW-1:DW/2] real, [DW/2-1:0] imag)
//   out_valid/ready   beat handshake
//   out_data          current word, out_idx its bin, out_last on the 8th beat
//   busy              a frame is held and not yet fully sent

module fft_out_serializer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] b1,
    input  logic [DW-1:0] b2,
    input  logic [DW-1:0] b3,
    input  logic [DW-1:0] b4,
    input  logic [DW-1:0] b5,
    input  logic [DW-1:0] b6,
    input  logic [DW-1:0] b7,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    localparam int N  = 8;
    localparam int IW = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] cnt;
    logic [DW-1:0] frame_buf [N];
    logic [IW-1:0] sel;
    logic          last_beat;
    logic          capture;

`ifdef FFT_OUT_BITREV_EN
    assign sel = {cnt[0], cnt[1], cnt[2]};
`else
    assign sel = cnt;
`endif

    assign last_beat = (state == SEND) && (cnt == IW'(N - 1));

    // Ready on the final beat lets the next frame land with no bubble.
    assign in_ready = (state == IDLE) || (last_beat && out_ready);
    assign capture  = in_valid && in_ready;

    // Outputs come straight from state/cnt/frame_buf; forced to zero while idle.
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_data  = (state == SEND) ? frame_buf[sel] : '0;
    assign out_idx   = (state == SEND) ? sel : '0;
    assign out_last  = last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            for (int k = 0; k < N; k++) begin
                frame_buf[k] <= '0;
            end
        end else begin
            if (capture) begin
                frame_buf[0] <= b0;
                frame_buf[1] <= b1;
                frame_buf[2] <= b2;
                frame_buf[3] <= b3;
                frame_buf[4] <= b4;
                frame_buf[5] <= b5;
                frame_buf[6] <= b6;
                frame_buf[7] <= b7;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= SEND;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (last_beat) begin
                            cnt <= '0;
                            if (!in_valid) begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - self-checking bench for fft_out_serializer

module tb_fft_out_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] b [8];
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef FFT_OUT_BITREV_EN
    localparam int ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    typedef struct {
        logic [31:0] d;
        logic [2:0]  i;
        logic        l;
    } beat_t;

    beat_t q[$];

    fft_out_serializer #(.DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .b0       (b[0]),
        .b1       (b[1]),
        .b2       (b[2]),
        .b3       (b[3]),
        .b4       (b[4]),
        .b5       (b[5]),
        .b6       (b[6]),
        .b7       (b[7]),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [38:0] dut_vec;
    assign dut_vec = {out_valid, busy, in_ready,
                      out_valid ? {out_data, out_idx, out_last} : 36'b0};

    // Reference: pending beats of the frame in flight. A frame is accepted when
    // nothing is pending, or only the last beat is pending and it is being taken.
    function automatic logic model_rdy();
        return (q.size() == 0) || (q.size() == 1 && out_ready);
    endfunction

    function automatic logic [38:0] model_vec();
        logic [38:0] v;
        v = {1'b0, 1'b0, model_rdy(), 36'b0};
        if (q.size() > 0) v = {1'b1, 1'b1, model_rdy(), q[0].d, q[0].i, q[0].l};
        return v;
    endfunction

    function automatic logic model_step();
        logic acc;
        logic fire;
        acc  = in_valid && model_rdy();
        fire = (q.size() > 0) && out_ready;
        if (fire) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                beat_t e;
                e.d = b[ORD[k]];
                e.i = 3'(ORD[k]);
                e.l = (k == 7);
                q.push_back(e);
            end
        end
        return acc;
    endfunction

    task automatic load_frame(input logic [31:0] base);
        for (int k = 0; k < 8; k++) b[k] = base + 32'(k);
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_frame(32'h0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, out_data, out_idx, out_last} !== 38'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b busy=%b d=%h idx=%0d last=%b exp all 0",
                     out_valid, busy, out_data, out_idx, out_last);
        end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int beats = 0;
        load_frame(32'h0100_0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            logic acc;
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL single cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            if (out_valid) beats++;
            acc = model_step();
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                for (int k = 0; k < 8; k++) b[k] = $urandom;
            end
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL single_beats got %0d exp 8", beats);
        end
    endtask

    task automatic test_backpressure();
        int vcyc = 0;
        load_frame(32'h0200_0000);
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            logic acc;
            out_ready = !(i >= 3 && i <= 5);
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL backpressure cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            if (out_valid) vcyc++;
            acc = model_step();
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        checks++;
        if (vcyc != 11) begin
            errors++;
            $display("FAIL backpressure_cycles got %0d exp 11", vcyc);
        end
    endtask

    task automatic test_back_to_back();
        int vcyc = 0;
        int nacc = 0;
        int b_acc_cyc = -1;
        load_frame(32'h0A00_0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic acc;
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            if (out_valid) vcyc++;
            acc = model_step();
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) load_frame(32'h0B00_0000);
                else begin
                    b_acc_cyc = i;
                    in_valid  = 1'b0;
                end
            end
        end
        checks++;
        if (vcyc != 16 || b_acc_cyc != 8) begin
            errors++;
            $display("FAIL back_to_back_gap got beats=%0d b_accept=%0d exp 16 8", vcyc, b_acc_cyc);
        end
    endtask

    task automatic test_reset_mid();
        load_frame(32'h0300_0000);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic acc;
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL reset_mid_pre cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            acc = model_step();
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort got out_valid=%b busy=%b exp 0 0", out_valid, busy);
        end
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_frame(32'h0C00_0000);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic acc;
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL reset_mid_post cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            acc = model_step();
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic acc;
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid) begin
                for (int k = 0; k < 8; k++) b[k] = $urandom;
                in_valid = ($urandom_range(2) == 0);
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %h exp %h", i, dut_vec, model_vec());
            end
            acc = model_step();
            @(posedge clk); #1;
            if (acc) in_valid = ($urandom_range(1) == 0);
            if (acc && in_valid) for (int k = 0; k < 8; k++) b[k] = $urandom;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        load_frame(32'h0);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
